// File: rtl/mc_control_fsm.sv
// Moore control FSM for the multi-cycle MIPS datapath: sequences fetch/decode/execute/
// memory/write-back and drives every datapath select and write enable from the state register.
module mc_control_fsm #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_J     = 6'h02,
    parameter logic [5:0] OP_ADDI  = 6'h08
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11
    } state_t;

    state_t cur_state;
    state_t next_state;

    always_ff @(posedge clk) begin
        if (reset) cur_state <= FETCH;
        else       cur_state <= next_state;
    end

    always_comb begin
        next_state = FETCH;
        case (cur_state)
            FETCH:  next_state = DECODE;
            DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW) next_state = MEMADR;
                else if (opcode == OP_RTYPE)            next_state = EXEC;
                else if (opcode == OP_BEQ)              next_state = BRANCH;
                else if (opcode == OP_J)                next_state = JUMP;
                else if (opcode == OP_ADDI)             next_state = ADDIEX;
                else                                    next_state = FETCH;
            end
            MEMADR: begin
                if (opcode == OP_LW)      next_state = MEMRD;
                else if (opcode == OP_SW) next_state = MEMWR;
                else                      next_state = FETCH;
            end
            MEMRD:  next_state = MEMWB;
            EXEC:   next_state = ALUWB;
            ADDIEX: next_state = ADDIWB;
            default: next_state = FETCH;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        if (reset) begin
            // Hold FETCH selects with every write enable suppressed.
            ALUSrcB = 2'b01;
        end else begin
            case (cur_state)
                FETCH: begin
                    MemRead = 1'b1;
                    IRWrite = 1'b1;
                    ALUSrcB = 2'b01;
                    PCWrite = 1'b1;
                end
                DECODE: ALUSrcB = 2'b11;
                MEMADR, ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                ALUWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                ADDIWB: RegWrite = 1'b1;
                BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                end
                JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign PCEn  = PCWrite | (PCWriteCond & Zero);
    assign state = cur_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: per-cycle expected state and output vector are queued
// from a reference table when an instruction is issued and compared as the FSM steps.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       Zero;
    logic       PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite, IRWrite;
    logic       RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    typedef struct packed {
        logic [3:0]  st;
        logic [16:0] outs;
    } exp_t;

    exp_t sb[$];

    mc_control_fsm #(
        .OP_RTYPE(6'h00), .OP_LW(6'h23), .OP_SW(6'h2B),
        .OP_BEQ(6'h04), .OP_J(6'h02), .OP_ADDI(6'h08)
    ) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .Zero(Zero),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCEn(PCEn), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .PCSource(PCSource), .state(state)
    );

    always #5 clk = ~clk;

    logic [16:0] dut_vec;
    assign dut_vec = {PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite, IRWrite,
                      RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_next(input logic [3:0] s, input logic [5:0] op);
        case (s)
            4'd0: return 4'd1;
            4'd1: case (op)
                6'h23, 6'h2B: return 4'd2;
                6'h00:        return 4'd6;
                6'h04:        return 4'd8;
                6'h02:        return 4'd9;
                6'h08:        return 4'd10;
                default:      return 4'd0;
            endcase
            4'd2:  return (op == 6'h23) ? 4'd3 : 4'd5;
            4'd3:  return 4'd4;
            4'd6:  return 4'd7;
            4'd10: return 4'd11;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [16:0] ref_outs(input logic [3:0] s, input logic rst, input logic z);
        logic pw, pwc, iord, mr, mw, irw, rd, m2r, rw, asa;
        logic [1:0] asb, aop, psrc;
        {pw, pwc, iord, mr, mw, irw, rd, m2r, rw, asa} = '0;
        asb = 2'd0; aop = 2'd0; psrc = 2'd0;
        case (s)
            4'd0:        begin mr = 1; irw = 1; asb = 2'd1; pw = 1; end
            4'd1:        asb = 2'd3;
            4'd2, 4'd10: begin asa = 1; asb = 2'd2; end
            4'd3:        begin mr = 1; iord = 1; end
            4'd4:        begin rw = 1; m2r = 1; end
            4'd5:        begin mw = 1; iord = 1; end
            4'd6:        begin asa = 1; aop = 2'd2; end
            4'd7:        begin rw = 1; rd = 1; end
            4'd8:        begin asa = 1; aop = 2'd1; pwc = 1; psrc = 2'd1; end
            4'd9:        begin pw = 1; psrc = 2'd2; end
            4'd11:       rw = 1;
            default: ;
        endcase
        if (rst) begin
            {pw, pwc, iord, mr, mw, irw, rd, m2r, rw, asa} = '0;
            asb = 2'd1; aop = 2'd0; psrc = 2'd0;
        end
        return {pw, pwc, pw | (pwc & z), iord, mr, mw, irw, rd, m2r, rw, asa, asb, aop, psrc};
    endfunction

    task automatic push_exp(input logic [3:0] s, input logic rst, input logic z);
        exp_t e;
        e.st   = s;
        e.outs = ref_outs(s, rst, z);
        sb.push_back(e);
    endtask

    task automatic compare_head(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({tag, "_state"}, {28'd0, state}, {28'd0, e.st});
        check({tag, "_outs"}, {15'd0, dut_vec}, {15'd0, e.outs});
    endtask

    // Issue one instruction from FETCH; queue its whole reference trace, then step through it.
    task automatic run_instr(input string tag, input logic [5:0] op, input logic z);
        logic [3:0] s;
        opcode = op;
        Zero   = z;
        s = 4'd0;
        for (int i = 0; i < 8; i++) begin
            push_exp(s, 1'b0, z);
            s = ref_next(s, op);
            if (s == 4'd0) break;
        end
        while (sb.size() > 0) begin
            compare_head(tag);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
        $fatal(1);
    end

    initial begin
        reset  = 1'b1;
        opcode = 6'h3F;
        Zero   = 1'b0;
        @(posedge clk); #1;
        push_exp(4'd0, 1'b1, 1'b0);
        compare_head("rst1");
        @(posedge clk); #1;
        push_exp(4'd0, 1'b1, 1'b0);
        compare_head("rst2");
        reset = 1'b0;
        #1;

        run_instr("lw",    6'h23, 1'b0);
        run_instr("sw",    6'h2B, 1'b1);
        run_instr("rtype", 6'h00, 1'b0);
        run_instr("addi",  6'h08, 1'b0);
        run_instr("beq_z1", 6'h04, 1'b1);
        run_instr("beq_z0", 6'h04, 1'b0);
        run_instr("j",     6'h02, 1'b0);
        run_instr("bad_op", 6'h3F, 1'b0);

        // Abort a load in MEMRD with reset: nothing may be written.
        opcode = 6'h23;
        Zero   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_exp(i[3:0], 1'b0, 1'b0);
            compare_head("lw_abort_pre");
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        push_exp(4'd3, 1'b1, 1'b0);
        compare_head("lw_abort_in_rst");
        @(posedge clk); #1;
        push_exp(4'd0, 1'b1, 1'b0);
        compare_head("lw_abort_after_edge");
        reset = 1'b0;
        #1;

        run_instr("lw_after_abort", 6'h23, 1'b0);
        run_instr("beq_final", 6'h04, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
